// File: rtl/types_pkg.sv
// Shared types for the fetch stage.
//   word_t        : 32-bit machine word
//   fetch_entry_t : buffered instruction tagged with its PC
//   INSTR_BYTES   : byte stride between consecutive instructions
//   align_word()  : clears the byte-offset bits of an address
package types_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  function automatic word_t align_word(input word_t addr);
    return addr & ~word_t'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t used as the fetch buffer.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   push        : write push_data (ignored when full unless popping)
//   push_data   : entry to enqueue
//   pop         : remove head (ignored when empty)
//   flush       : drop all entries; wins over push/pop
//   head        : current head entry (valid when !empty)
//   empty       : no entries held
//   count       : number of entries held (0..DEPTH)
module fetch_fifo
  import types_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 head,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO can still accept a write when the head leaves in the same cycle.
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues in-order word requests over a
// req/gnt/rvalid interface, buffers PC-tagged responses and hands them to
// the core over valid/ready. A redirect flushes the buffer and marks every
// still-outstanding response for discard.
// Optional feature: define FETCH_BYPASS_EN to forward a response straight
// to the core in the same cycle when the buffer is empty.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   redirect_i/_pc_i      : restart fetch at redirect_pc_i (word aligned)
//   imem_req_o/_addr_o    : request valid / word address
//   imem_gnt_i            : request accepted
//   imem_rvalid_i/_rdata_i: in-order response
//   instr_valid_o/instr_o/pc_o : buffer head to the core
//   instr_ready_i         : core consumes head
module instr_fetch_unit
  import types_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter word_t       RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        instr_ready_i
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SW = CW + 1;
  localparam logic [OW-1:0] MAX_O   = OW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

  word_t          fetch_pc;
  word_t          resp_pc;
  logic [OW-1:0]  outstanding;
  logic [OW-1:0]  discard;

  logic [CW-1:0]  fifo_count;
  logic           fifo_empty;
  fetch_entry_t   fifo_head;
  logic           fifo_push;
  logic           fifo_pop;

  logic           accept;
  logic           rsp;
  logic           keep;
  logic           bypass;
  logic [SW-1:0]  occupancy;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp       = imem_rvalid_i && (outstanding != '0);
  assign keep      = rsp && (discard == '0);
  assign accept    = imem_req_o && imem_gnt_i;
  // Buffer space is reserved for every outstanding request, so a response
  // can always be pushed.
  assign occupancy = SW'(fifo_count) + SW'(outstanding);

  assign imem_req_o  = !reset && !redirect_i && (outstanding < MAX_O) &&
                       (occupancy < DEPTH_S);
  assign imem_addr_o = fetch_pc;

`ifdef FETCH_BYPASS_EN
  assign bypass  = keep && fifo_empty && !redirect_i;
  assign instr_o = fifo_empty ? imem_rdata_i : fifo_head.instr;
  assign pc_o    = fifo_empty ? resp_pc      : fifo_head.pc;
`else
  assign bypass  = 1'b0;
  assign instr_o = fifo_head.instr;
  assign pc_o    = fifo_head.pc;
`endif

  assign instr_valid_o = !reset && (!fifo_empty || bypass);
  assign fifo_pop      = instr_ready_i && !fifo_empty;
  // A bypassed word the core takes immediately never enters the buffer.
  assign fifo_push     = keep && !redirect_i && !(bypass && instr_ready_i);

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ('{pc: resp_pc, instr: imem_rdata_i}),
    .pop       (fifo_pop),
    .flush     (redirect_i),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + OW'(accept) - OW'(rsp);
      if (redirect_i) begin
        fetch_pc <= align_word(redirect_pc_i);
        resp_pc  <= align_word(redirect_pc_i);
        // Everything still in flight after this cycle belongs to the old stream.
        discard  <= outstanding - OW'(rsp);
      end else begin
        if (accept) fetch_pc <= fetch_pc + word_t'(INSTR_BYTES);
        if (rsp) begin
          if (discard != '0) discard <= discard - OW'(1);
          else               resp_pc <= resp_pc + word_t'(INSTR_BYTES);
        end
      end
    end
  end

`ifndef SYNTHESIS
  rvalid_needs_outstanding: assert property (
    @(posedge clk) disable iff (reset) imem_rvalid_i |-> (outstanding != '0));
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAXO     = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_ready_i;

  instr_fetch_unit #(
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .RESET_PC        (RESET_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .instr_ready_i (instr_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: memory requests in flight (tagged with the fetch stream
  // they belong to) and the PCs of words waiting for the core.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          issued;
  } req_t;

  req_t        pend[$];
  logic [31:0] buf_q[$];
  int          epoch   = 0;
  logic [31:0] m_fetch = RESET_PC;

  // Expected / actual values of the most recent cycle.
  bit          e_req, e_valid;
  logic [31:0] e_addr, e_pc, e_instr;
  logic        a_req, a_valid;
  logic [31:0] a_addr, a_pc, a_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
  endfunction

  // One clock of stimulus: drive inputs, sample outputs, compute expected
  // outputs from the model, then advance the model past the rising edge.
  task automatic step(input bit g, input bit rv_en, input bit rdy,
                      input bit redir, input logic [31:0] tgt, input bit rst);
    req_t r;
    bit   rv, byp, byp_taken;
    @(negedge clk);
    rv = 1'b0;
    if (!rst && rv_en && pend.size() != 0) rv = (pend[0].issued < cyc);
    reset         = rst;
    redirect_i    = redir;
    redirect_pc_i = tgt;
    imem_gnt_i    = g;
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? mem_word(pend[0].addr) : $urandom;
    instr_ready_i = rdy;
    #1;
    a_req = imem_req_o;  a_addr = imem_addr_o;
    a_valid = instr_valid_o; a_pc = pc_o; a_instr = instr_o;
    e_addr = m_fetch;
    if (rst) begin
      e_req = 1'b0; e_valid = 1'b0; e_pc = '0; e_instr = '0;
      pend.delete(); buf_q.delete();
      m_fetch = RESET_PC; epoch++; cyc++;
      return;
    end
    e_req = !redir && (pend.size() < MAXO) && (buf_q.size() + pend.size() < DEPTH);
    byp = 1'b0;
`ifdef FETCH_BYPASS_EN
    if (rv && buf_q.size() == 0 && !redir) byp = (pend[0].epoch == epoch);
`endif
    e_valid = (buf_q.size() != 0) || byp;
    e_pc    = (buf_q.size() != 0) ? buf_q[0] : (byp ? pend[0].addr : 32'h0);
    e_instr = mem_word(e_pc);
    byp_taken = byp && rdy;
    if (rv) r = pend.pop_front();
    if (redir) begin
      buf_q.delete();
      epoch++;
      m_fetch = tgt & 32'hFFFF_FFFC;
    end else begin
      if (rdy && buf_q.size() != 0) void'(buf_q.pop_front());
      if (rv && r.epoch == epoch && !byp_taken) buf_q.push_back(r.addr);
      if (e_req && g) begin
        pend.push_back('{addr: m_fetch, epoch: epoch, issued: cyc});
        m_fetch = m_fetch + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      checks++;
      if (a_req !== 1'b0) begin
        errors++; $display("FAIL reset_req: got %b want 0", a_req);
      end
      checks++;
      if (a_valid !== 1'b0) begin
        errors++; $display("FAIL reset_valid: got %b want 0", a_valid);
      end
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checks++;
    if (a_req !== 1'b1 || a_addr !== RESET_PC) begin
      errors++; $display("FAIL reset_first_req: req=%b addr=%h want req=1 addr=%h",
                         a_req, a_addr, RESET_PC);
    end
  endtask

  task automatic test_zero_wait();
    int delivered = 0;
    int want;
`ifdef FETCH_BYPASS_EN
    want = 39;
`else
    want = 38;
`endif
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      checks++;
      if (a_req !== e_req || (e_req && a_addr !== e_addr)) begin
        errors++; $display("FAIL zw_req: req=%b addr=%h want req=%b addr=%h",
                           a_req, a_addr, e_req, e_addr);
      end
      checks++;
      if (a_valid !== e_valid || (e_valid && (a_pc !== e_pc || a_instr !== e_instr))) begin
        errors++; $display("FAIL zw_out: valid=%b pc=%h instr=%h want valid=%b pc=%h instr=%h",
                           a_valid, a_pc, a_instr, e_valid, e_pc, e_instr);
      end
      if (a_valid === 1'b1) delivered++;
    end
    checks++;
    if (delivered != want) begin
      errors++; $display("FAIL zw_throughput: got %0d words want %0d", delivered, want);
    end
  endtask

  task automatic test_backpressure();
    int delivered = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      checks++;
      if (a_req !== e_req || a_valid !== e_valid || (e_valid && a_pc !== e_pc)) begin
        errors++; $display("FAIL bp_stall: req=%b valid=%b pc=%h want req=%b valid=%b pc=%h",
                           a_req, a_valid, a_pc, e_req, e_valid, e_pc);
      end
    end
    checks++;
    if (a_req !== 1'b0 || a_valid !== 1'b1) begin
      errors++; $display("FAIL bp_full: req=%b valid=%b want req=0 valid=1", a_req, a_valid);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      checks++;
      if (a_valid !== e_valid || (e_valid && (a_pc !== e_pc || a_instr !== e_instr))) begin
        errors++; $display("FAIL bp_drain: valid=%b pc=%h instr=%h want valid=%b pc=%h instr=%h",
                           a_valid, a_pc, a_instr, e_valid, e_pc, e_instr);
      end
      if (a_valid === 1'b1) delivered++;
    end
    checks++;
    if (delivered != DEPTH) begin
      errors++; $display("FAIL bp_count: got %0d words want %0d", delivered, DEPTH);
    end
  endtask

  // Two requests outstanding, then a redirect; rv_at_redirect makes one of
  // the stale responses arrive in the redirect cycle itself.
  task automatic run_redirect(input string name, input bit rv_at_redirect,
                              input logic [31:0] tgt, input logic [31:0] want_pc);
    bit seen = 1'b0;
    logic [31:0] first_pc = '0;
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, rv_at_redirect, 1'b1, 1'b1, tgt, 1'b0);
    checks++;
    if (a_req !== 1'b0) begin
      errors++; $display("FAIL %s_req_in_redirect: got %b want 0", name, a_req);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      checks++;
      if (a_valid !== e_valid || (e_valid && (a_pc !== e_pc || a_instr !== e_instr))) begin
        errors++; $display("FAIL %s_out: valid=%b pc=%h instr=%h want valid=%b pc=%h instr=%h",
                           name, a_valid, a_pc, a_instr, e_valid, e_pc, e_instr);
      end
      if (a_valid === 1'b1 && !seen) begin seen = 1'b1; first_pc = a_pc; end
    end
    checks++;
    if (!seen || first_pc !== want_pc) begin
      errors++; $display("FAIL %s_first_pc: seen=%b pc=%h want %h", name, seen, first_pc, want_pc);
    end
  endtask

  task automatic test_gnt_stall();
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      checks++;
      if (a_req !== 1'b1 || a_addr !== 32'h8) begin
        errors++; $display("FAIL stall_hold: req=%b addr=%h want req=1 addr=00000008",
                           a_req, a_addr);
      end
    end
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checks++;
    if (a_addr !== 32'hC) begin
      errors++; $display("FAIL stall_advance: addr=%h want 0000000c", a_addr);
    end
  endtask

  task automatic test_wrap_and_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checks++;
    if (a_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_first: addr=%h want fffffffc", a_addr);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checks++;
    if (a_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_next: addr=%h want 00000000", a_addr);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      checks++;
      if (a_valid !== e_valid || (e_valid && (a_pc !== e_pc || a_instr !== e_instr))) begin
        errors++; $display("FAIL wrap_out: valid=%b pc=%h want valid=%b pc=%h",
                           a_valid, a_pc, e_valid, e_pc);
      end
    end
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if (a_valid !== 1'b0 || a_req !== 1'b0) begin
      errors++; $display("FAIL midreset: valid=%b req=%b want 0 0", a_valid, a_req);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checks++;
    if (a_req !== 1'b1 || a_addr !== RESET_PC || a_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_restart: req=%b addr=%h valid=%b want 1 %h 0",
                         a_req, a_addr, a_valid, RESET_PC);
    end
  endtask

  task automatic test_random();
    bit g, rv, rdy, redir;
    logic [31:0] tgt;
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 2000; i++) begin
      g     = ($urandom_range(0, 3) != 0);
      rv    = ($urandom_range(0, 2) != 0);
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 24) == 0);
      tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : $urandom;
      step(g, rv, rdy, redir, tgt, 1'b0);
      checks++;
      if (a_req !== e_req || (e_req && a_addr !== e_addr)) begin
        errors++; $display("FAIL rand_req @%0d: req=%b addr=%h want req=%b addr=%h",
                           cyc, a_req, a_addr, e_req, e_addr);
      end
      checks++;
      if (a_valid !== e_valid || (e_valid && (a_pc !== e_pc || a_instr !== e_instr))) begin
        errors++; $display("FAIL rand_out @%0d: valid=%b pc=%h instr=%h want valid=%b pc=%h instr=%h",
                           cyc, a_valid, a_pc, a_instr, e_valid, e_pc, e_instr);
      end
    end
  endtask

  initial begin
    reset = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0; instr_ready_i = 1'b0;
    test_reset();
    test_zero_wait();
    test_backpressure();
    run_redirect("redir", 1'b0, 32'h0000_0103, 32'h0000_0100);
    run_redirect("redir_rv", 1'b1, 32'h0000_0200, 32'h0000_0200);
    test_gnt_stall();
    test_wrap_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
